// File: rtl/spi_multi_pkg.sv
// Shared types and register layout for the multi-device SPI master slot.
// The engine configuration snapshot is a packed struct so it can be latched as one unit.
package spi_multi_pkg;

  typedef enum logic [1:0] {IDLE, P0, P1} state_t;

  localparam logic [1:0] REG_RX   = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_SS   = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_DATA = 2'd3;

  localparam int CTRL_DVSR  = 0;
  localparam int CTRL_CPOL  = 16;
  localparam int CTRL_CPHA  = 17;
  localparam int CTRL_LSB   = 18;
  localparam int CTRL_LEN   = 20;
  // Length field is decoded one bit wider than needed so oversize values clamp instead of wrapping.
  localparam int CTRL_LEN_W = 6;
  localparam int LEN_MAX_W  = 5;

  localparam logic [15:0] DVSR_RST = 16'd49;

  typedef struct packed {
    logic [15:0]          dvsr;
    logic                 cpol;
    logic                 cpha;
    logic                 lsb_first;
    logic [LEN_MAX_W-1:0] len;
  } spi_cfg_t;

  // Data-word position of the n-th bit on the wire.
  function automatic logic [LEN_MAX_W-1:0] bit_pos(input logic lsb_first,
                                                   input logic [LEN_MAX_W-1:0] len,
                                                   input logic [LEN_MAX_W-1:0] n);
    return lsb_first ? n : len - n;
  endfunction

endpackage

// File: rtl/spi_master_multi_core_engine.sv
// Serial engine: phase FSM, clock divider, bit counter, tx/rx registers and sclk/mosi.
// Config is snapshotted on start so register writes during a transfer cannot disturb it.
module spi_master_engine
  import spi_multi_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  spi_cfg_t     cfg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         ready,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso
);

  state_t               state_q, state_d;
  spi_cfg_t             snap_q, snap_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [LEN_MAX_W-1:0] bit_q, bit_d;
  logic [W-1:0]         tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic                 ready_q, ready_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic                 tick, phase_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      snap_q  <= '{dvsr: DVSR_RST, cpol: 1'b0, cpha: 1'b0, lsb_first: 1'b0,
                   len: LEN_MAX_W'(W-1)};
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      ready_q <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign tick = (cnt_q == snap_q.dvsr);

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    dout_d   = dout_q;
    ready_d  = ready_q;
    mosi_d   = mosi_q;
    case (state_q)
      IDLE: if (start) begin
        snap_d  = cfg;
        tx_d    = din;
        rx_d    = '0;
        bit_d   = '0;
        cnt_d   = '0;
        ready_d = 1'b0;
        state_d = P0;
        mosi_d  = din[bit_pos(cfg.lsb_first, cfg.len, '0)];
      end
      P0: if (tick) begin
        cnt_d = '0;
        rx_d[bit_pos(snap_q.lsb_first, snap_q.len, bit_q)] = miso;
        state_d = P1;
      end else cnt_d = cnt_q + 16'd1;
      P1: if (tick) begin
        cnt_d = '0;
        if (bit_q == snap_q.len) begin
          state_d = IDLE;
          ready_d = 1'b1;
          dout_d  = rx_q;
        end else begin
          bit_d   = bit_q + 1'b1;
          state_d = P0;
          mosi_d  = tx_q[bit_pos(snap_q.lsb_first, snap_q.len, bit_q + 1'b1)];
        end
      end else cnt_d = cnt_q + 16'd1;
      default: state_d = IDLE;
    endcase
    // sclk is derived from the next state so the pin lines up with the phase register.
    phase_hi = snap_d.cpha ? (state_d == P0) : (state_d == P1);
    sclk_d   = (state_d == IDLE) ? snap_d.cpol : (phase_hi ^ snap_d.cpol);
  end

  assign dout  = dout_q;
  assign ready = ready_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;

endmodule

// File: rtl/spi_master_multi_core.sv
// MMIO wrapper: decodes slot writes into ss/ctrl registers, starts the engine, muxes reads.
// Slave selects are software-owned and follow register writes immediately.
module spi_master_multi_core
  import spi_multi_pkg::*;
#(
  parameter int W     = 32,
  parameter int N_SS  = 4,
  parameter int LEN_W = $clog2(W)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            read,
  input  logic            write,
  input  logic [4:0]      addr,
  input  logic [31:0]     wr_data,
  output logic [31:0]     rd_data,
  output logic            spi_sclk,
  output logic            spi_mosi,
  input  logic            spi_miso,
  output logic [N_SS-1:0] spi_ss_n
);

  localparam logic [CTRL_LEN_W-1:0] LEN_CAP = CTRL_LEN_W'(W-1);

  logic [N_SS-1:0]       ss_n_q;
  logic [15:0]           dvsr_q;
  logic                  cpol_q, cpha_q, lsb_q;
  logic [LEN_W-1:0]      len_q;
  logic [CTRL_LEN_W-1:0] len_wr;
  logic                  wr_en, start, ready;
  logic [W-1:0]          rx;
  spi_cfg_t              cfg;
  logic                  unused_ok;

  assign unused_ok = ^{read, addr[4:2]};
  assign wr_en  = cs && write;
  assign start  = wr_en && (addr[1:0] == REG_DATA);
  assign len_wr = wr_data[CTRL_LEN +: CTRL_LEN_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      ss_n_q <= '1;
      dvsr_q <= DVSR_RST;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q  <= 1'b0;
      len_q  <= LEN_W'(W-1);
    end else if (wr_en) begin
      case (addr[1:0])
        REG_SS: ss_n_q <= wr_data[N_SS-1:0];
        REG_CTRL: begin
          dvsr_q <= wr_data[CTRL_DVSR +: 16];
          cpol_q <= wr_data[CTRL_CPOL];
          cpha_q <= wr_data[CTRL_CPHA];
          lsb_q  <= wr_data[CTRL_LSB];
          len_q  <= (len_wr > LEN_CAP) ? LEN_CAP[LEN_W-1:0] : len_wr[LEN_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign cfg = '{dvsr: dvsr_q, cpol: cpol_q, cpha: cpha_q, lsb_first: lsb_q,
                 len: LEN_MAX_W'(len_q)};

  spi_master_engine #(.W(W)) u_engine (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .cfg   (cfg),
    .din   (wr_data[W-1:0]),
    .dout  (rx),
    .ready (ready),
    .sclk  (spi_sclk),
    .mosi  (spi_mosi),
    .miso  (spi_miso)
  );

  always_comb begin
    rd_data = '0;
    case (addr[1:0])
      REG_RX:   rd_data[W-1:0] = rx;
      REG_STAT: rd_data[0]     = ready;
      default:  ;
    endcase
  end

  assign spi_ss_n = ss_n_q;

endmodule

// File: tb/tb_spi_master_multi_core.sv
// Directed bench for the multi-device SPI master: loopback and a mode-3 slave model,
// with busy time, sclk edges/period, mosi order and rx contents checked against hand values.
module tb_spi_master_multi_core;

  logic        clk = 1'b0, reset = 1'b1, cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0]  addr = 5'd1;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        spi_sclk, spi_mosi, spi_miso;
  logic [3:0]  spi_ss_n;

  logic        loop = 1'b1, slave_miso = 1'b0;
  logic [15:0] slave_word = 16'h3C5A;
  int          scnt = 0;

  int          checks = 0, errors = 0;
  int          rises = 0, falls = 0, cyc = 0, last_rise = -1, period = 0;
  logic [31:0] seq = '0;
  logic        sclk_prev = 1'b0;

  spi_master_multi_core dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_ss_n(spi_ss_n)
  );

  always #5 clk = ~clk;

  assign spi_miso = loop ? spi_mosi : slave_miso;

  // Mode-3 slave on ss_n[0]: shifts its word out MSB-first on each leading (falling) edge.
  always @(negedge spi_sclk or posedge spi_ss_n[0]) begin
    if (spi_ss_n[0]) scnt = 0;
    else begin
      if (scnt < 16) slave_miso = slave_word[15-scnt];
      scnt = scnt + 1;
    end
  end

  // sclk edge monitor; mosi is captured on each rising edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (spi_sclk && !sclk_prev) begin
      rises = rises + 1;
      seq = {seq[30:0], spi_mosi};
      if (last_rise >= 0) period = cyc - last_rise;
      last_rise = cyc;
    end
    if (!spi_sclk && sclk_prev) falls = falls + 1;
    sclk_prev = spi_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = {3'b0, a}; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; addr = 5'd1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    cs = 1'b1; read = 1'b1; addr = {3'b0, a};
    #1 v = rd_data;
    cs = 1'b0; read = 1'b0; addr = 5'd1;
  endtask

  // Counts cycles with ready low, starting at the current negedge.
  task automatic wait_ready(output int n);
    logic done;
    done = 1'b0;
    n = 0;
    for (int k = 0; k < 20000 && !done; k++) begin
      #1;
      if (rd_data[0]) done = 1'b1;
      else begin
        n++;
        @(negedge clk);
      end
    end
    if (!done) chk("ready_timeout", {31'b0, rd_data[0]}, 32'd1);
  endtask

  task automatic xfer(input logic [31:0] tx, output int busy);
    bus_write(2'd3, tx);
    wait_ready(busy);
  endtask

  initial begin
    logic [31:0] v;
    int busy, r0, f0;

    // 1: reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd(2'd1, v);  chk("rst_ready", v, 32'd1);
    rd(2'd0, v);  chk("rst_rx", v, 32'd0);
    chk("rst_ss", {28'b0, spi_ss_n}, 32'hF);
    chk("rst_sclk", {31'b0, spi_sclk}, 32'd0);
    chk("rst_mosi", {31'b0, spi_mosi}, 32'd0);

    // 2: mode 0, dvsr 0, 8 bits MSB-first loopback
    bus_write(2'd2, 32'h0070_0000);
    r0 = rises;
    xfer(32'hA5, busy);
    chk("m0_busy", busy, 32'd16);
    chk("m0_rises", rises - r0, 32'd8);
    chk("m0_mosi_seq", {24'b0, seq[7:0]}, 32'hA5);
    chk("m0_period", period, 32'd2);
    rd(2'd0, v);  chk("m0_rx", v, 32'hA5);

    // 3: mode 3, dvsr 3; a 1-bit transfer first so the snapshot idles sclk high
    loop = 1'b0;
    bus_write(2'd2, 32'h0003_0003);
    xfer(32'h0, busy);
    chk("m3_pre_busy", busy, 32'd8);
    chk("m3_idle_sclk", {31'b0, spi_sclk}, 32'd1);
    bus_write(2'd2, 32'h00F3_0003);
    bus_write(2'd1, 32'hE);
    f0 = falls;
    xfer(32'h0, busy);
    chk("m3_busy", busy, 32'd128);
    chk("m3_falls", falls - f0, 32'd16);
    chk("m3_idle_after", {31'b0, spi_sclk}, 32'd1);
    rd(2'd0, v);  chk("m3_rx", v, 32'h3C5A);
    bus_write(2'd1, 32'hF);
    loop = 1'b1;

    // 4: LSB-first, short asymmetric word then full 32 bits and a clamped length
    bus_write(2'd2, 32'h0074_0000);
    bus_write(2'd3, 32'h0D);
    chk("lsb8_first_mosi", {31'b0, spi_mosi}, 32'd1);
    wait_ready(busy);
    chk("lsb8_busy", busy, 32'd16);
    chk("lsb8_mosi_seq", {24'b0, seq[7:0]}, 32'hB0);
    rd(2'd0, v);  chk("lsb8_rx", v, 32'h0D);
    bus_write(2'd2, 32'h01F4_0000);
    bus_write(2'd3, 32'h8000_0001);
    chk("lsb32_first_mosi", {31'b0, spi_mosi}, 32'd1);
    wait_ready(busy);
    chk("lsb32_busy", busy, 32'd64);
    rd(2'd0, v);  chk("lsb32_rx", v, 32'h8000_0001);
    bus_write(2'd2, 32'h0284_0000);
    xfer(32'h8000_0001, busy);
    chk("clamp_busy", busy, 32'd64);
    rd(2'd0, v);  chk("clamp_rx", v, 32'h8000_0001);

    // 5: start and ctrl writes while busy
    bus_write(2'd2, 32'h0070_0001);
    bus_write(2'd3, 32'h12);
    bus_write(2'd3, 32'h34);
    bus_write(2'd2, 32'h0070_0009);
    rd(2'd0, v);  chk("busy_rx_prev", v, 32'h8000_0001);
    wait_ready(busy);
    chk("busy_period", period, 32'd4);
    rd(2'd0, v);  chk("busy_rx", v, 32'h12);
    xfer(32'h34, busy);
    chk("new_dvsr_busy", busy, 32'd160);
    chk("new_dvsr_period", period, 32'd20);
    rd(2'd0, v);  chk("new_dvsr_rx", v, 32'h34);

    // 6: reset in the middle of bit 3
    bus_write(2'd1, 32'hE);
    bus_write(2'd2, 32'h0070_0003);
    bus_write(2'd3, 32'hFF);
    repeat (26) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd(2'd1, v);  chk("mid_rst_ready", v, 32'd1);
    rd(2'd0, v);  chk("mid_rst_rx", v, 32'd0);
    chk("mid_rst_sclk", {31'b0, spi_sclk}, 32'd0);
    chk("mid_rst_mosi", {31'b0, spi_mosi}, 32'd0);
    chk("mid_rst_ss", {28'b0, spi_ss_n}, 32'hF);
    xfer(32'h5A, busy);
    chk("post_rst_busy", busy, 32'd3200);
    rd(2'd0, v);  chk("post_rst_rx", v, 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
